// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, ALU opcode bit positions and the divider
// state encoding.
package exe_stage_pkg;

    localparam int ID_TO_EXE_BUS_WD  = 161;
    localparam int EXE_TO_MEM_BUS_WD = 77;
    localparam int EXE_TO_BY_BUS_WD  = 40;

    localparam int ALU_OP_WD    = 19;
    localparam int ALU_OP_ADD   = 0;
    localparam int ALU_OP_SUB   = 1;
    localparam int ALU_OP_SLT   = 2;
    localparam int ALU_OP_SLTU  = 3;
    localparam int ALU_OP_AND   = 4;
    localparam int ALU_OP_NOR   = 5;
    localparam int ALU_OP_OR    = 6;
    localparam int ALU_OP_XOR   = 7;
    localparam int ALU_OP_SLL   = 8;
    localparam int ALU_OP_SRL   = 9;
    localparam int ALU_OP_SRA   = 10;
    localparam int ALU_OP_LUI   = 11;
    localparam int ALU_OP_MUL   = 12;
    localparam int ALU_OP_MULH  = 13;
    localparam int ALU_OP_MULHU = 14;
    localparam int ALU_OP_DIV   = 15;
    localparam int ALU_OP_MOD   = 16;
    localparam int ALU_OP_DIVU  = 17;
    localparam int ALU_OP_MODU  = 18;

    localparam logic [1:0] RAM_WD_WORD = 2'b00;
    localparam logic [1:0] RAM_WD_BYTE = 2'b01;
    localparam logic [1:0] RAM_WD_HALF = 2'b10;

    // First member lands in the MSBs, matching the ID->EXE bus packing.
    typedef struct packed {
        logic [2:0]           stage_sel;
        logic                 rf_we;
        logic                 rf_wsel;
        logic [1:0]           ram_wd;
        logic                 ram_we;
        logic                 ram_en;
        logic [31:0]          ram_wdata;
        logic [4:0]           rd;
        logic [ALU_OP_WD-1:0] alu_op;
        logic [31:0]          src2;
        logic [31:0]          src1;
        logic [31:0]          pc;
    } id_to_exe_t;

    typedef enum logic [1:0] {
        DivIdle,
        DivBusy,
        DivDone
    } div_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/exe_stage_divider.sv
// Iterative radix-2 restoring divider. Works on magnitudes and applies the sign on the way out;
// the result is held in DONE until the owning instruction leaves the stage.
module exe_divider
    import exe_stage_pkg::*;
#(
    parameter int unsigned DivCycles = 32
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic        ack_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    div_state_e  state_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic [5:0]  cnt_q;

    logic        a_neg;
    logic        b_neg;
    logic [32:0] shifted;
    logic [32:0] diff;

    assign a_neg   = signed_i & dividend_i[31];
    assign b_neg   = signed_i & divisor_i[31];
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= DivIdle;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                DivIdle: begin
                    if (start_i) begin
                        rem_q   <= '0;
                        quo_q   <= abs32(dividend_i, a_neg);
                        dvs_q   <= abs32(divisor_i, b_neg);
                        // Divide by zero keeps the all-ones quotient unsigned-looking.
                        q_neg_q <= (a_neg ^ b_neg) & (divisor_i != 32'd0);
                        r_neg_q <= a_neg;
                        cnt_q   <= '0;
                        state_q <= DivBusy;
                    end
                end
                DivBusy: begin
                    if (diff[32]) begin
                        rem_q <= shifted[31:0];
                        quo_q <= {quo_q[30:0], 1'b0};
                    end else begin
                        rem_q <= diff[31:0];
                        quo_q <= {quo_q[30:0], 1'b1};
                    end
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(DivCycles - 1)) begin
                        state_q <= DivDone;
                    end
                end
                DivDone: begin
                    if (ack_i) begin
                        state_q <= DivIdle;
                    end
                end
                default: state_q <= DivIdle;
            endcase
        end
    end

    assign busy_o      = (state_q == DivBusy);
    assign done_o      = (state_q == DivDone);
    assign quotient_o  = q_neg_q ? (~quo_q + 32'd1) : quo_q;
    assign remainder_o = r_neg_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches the ID->EXE bus, runs the ALU / multiplier / divider, issues the data RAM
// request and forwards results to MEM and to the bypass network.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ID_to_EXE_valid,
    input  logic [ID_TO_EXE_BUS_WD-1:0]  ID_to_EXE_bus,
    output logic                         EXE_allow_in,
    input  logic                         MEM_allow_in,
    output logic                         EXE_to_MEM_valid,
    output logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
    output logic [EXE_TO_BY_BUS_WD-1:0]  EXE_to_BY_bus,
    output logic                         data_sram_en,
    output logic [3:0]                   data_sram_we,
    output logic [31:0]                  data_sram_addr,
    output logic [31:0]                  data_sram_wdata
);

    logic       exe_valid_q;
    id_to_exe_t ex_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            exe_valid_q <= 1'b0;
            ex_q        <= '0;
        end else begin
            if (EXE_allow_in) begin
                exe_valid_q <= ID_to_EXE_valid;
            end
            if (ID_to_EXE_valid && EXE_allow_in) begin
                ex_q <= ID_to_EXE_bus;
            end
        end
    end

    logic [ALU_OP_WD-1:0] op;
    logic [31:0]          src1;
    logic [31:0]          src2;

    assign op   = ex_q.alu_op;
    assign src1 = ex_q.src1;
    assign src2 = ex_q.src2;

    logic        is_div;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        ready_go;
    logic        fire;

    assign is_div   = op[ALU_OP_DIV] | op[ALU_OP_MOD] | op[ALU_OP_DIVU] | op[ALU_OP_MODU];
    assign ready_go = ~is_div | div_done;
    assign fire     = exe_valid_q & ready_go & MEM_allow_in;

    assign EXE_allow_in     = ~exe_valid_q | (ready_go & MEM_allow_in);
    assign EXE_to_MEM_valid = exe_valid_q & ready_go;

    exe_divider #(
        .DivCycles(DIV_CYCLES)
    ) u_div (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (exe_valid_q & is_div & ~div_busy & ~div_done),
        .signed_i   (op[ALU_OP_DIV] | op[ALU_OP_MOD]),
        .ack_i      (fire),
        .dividend_i (src1),
        .divisor_i  (src2),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_q),
        .remainder_o(div_r)
    );

    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic        slt_res;
    logic        sltu_res;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] alu_result;

    assign add_res  = src1 + src2;
    assign sub_res  = src1 - src2;
    assign slt_res  = $signed(src1) < $signed(src2);
    assign sltu_res = src1 < src2;
    assign sll_res  = src1 << src2[4:0];
    assign srl_res  = src1 >> src2[4:0];
    assign sra_res  = $signed(src1) >>> src2[4:0];
    assign prod_s   = $signed({{32{src1[31]}}, src1}) * $signed({{32{src2[31]}}, src2});
    assign prod_u   = {32'd0, src1} * {32'd0, src2};

    always_comb begin
        alu_result = ({32{op[ALU_OP_ADD]}}   & add_res)
                   | ({32{op[ALU_OP_SUB]}}   & sub_res)
                   | ({32{op[ALU_OP_SLT]}}   & {31'd0, slt_res})
                   | ({32{op[ALU_OP_SLTU]}}  & {31'd0, sltu_res})
                   | ({32{op[ALU_OP_AND]}}   & (src1 & src2))
                   | ({32{op[ALU_OP_NOR]}}   & ~(src1 | src2))
                   | ({32{op[ALU_OP_OR]}}    & (src1 | src2))
                   | ({32{op[ALU_OP_XOR]}}   & (src1 ^ src2))
                   | ({32{op[ALU_OP_SLL]}}   & sll_res)
                   | ({32{op[ALU_OP_SRL]}}   & srl_res)
                   | ({32{op[ALU_OP_SRA]}}   & sra_res)
                   | ({32{op[ALU_OP_LUI]}}   & src2)
                   | ({32{op[ALU_OP_MUL]}}   & prod_u[31:0])
                   | ({32{op[ALU_OP_MULH]}}  & prod_s[63:32])
                   | ({32{op[ALU_OP_MULHU]}} & prod_u[63:32])
                   | ({32{op[ALU_OP_DIV]  | op[ALU_OP_DIVU]}} & div_q)
                   | ({32{op[ALU_OP_MOD]  | op[ALU_OP_MODU]}} & div_r);
    end

    logic [3:0]  store_we;
    logic [31:0] store_wdata;

    always_comb begin
        store_we    = 4'b1111;
        store_wdata = ex_q.ram_wdata;
        case (ex_q.ram_wd)
            RAM_WD_BYTE: begin
                store_we    = 4'b0001 << alu_result[1:0];
                store_wdata = {4{ex_q.ram_wdata[7:0]}};
            end
            RAM_WD_HALF: begin
                store_we    = 4'b0011 << {alu_result[1], 1'b0};
                store_wdata = {2{ex_q.ram_wdata[15:0]}};
            end
            default: ;
        endcase
        if (!ex_q.ram_we) begin
            store_we = 4'b0000;
        end
    end

    // The request goes out only in the cycle the instruction actually moves on to MEM.
    assign data_sram_en    = fire & ex_q.ram_en;
    assign data_sram_we    = data_sram_en ? store_we : 4'b0000;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = store_wdata;

    // ram_en is not forwarded; stage_sel[1] already marks loads for MEM.
    assign EXE_to_MEM_bus = {ex_q.stage_sel[2:1], ex_q.rf_we, ex_q.rf_wsel, ex_q.ram_wd,
                             alu_result[1:0], ex_q.rd, alu_result, ex_q.pc};

    logic data_valid;
    assign data_valid = ex_q.stage_sel[0] & ready_go;

    assign EXE_to_BY_bus = exe_valid_q
                         ? {ex_q.rd, alu_result, data_valid, 1'b1, ex_q.rf_we}
                         : '0;

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage: ALU vector table, divide table, store/load
// formatting, MEM back-pressure and reset in the middle of a divide.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic         clk;
    logic         reset;
    logic         id_valid;
    logic [160:0] id_bus;
    logic         exe_allow_in;
    logic         mem_allow_in;
    logic         mem_valid;
    logic [76:0]  mem_bus;
    logic [39:0]  by_bus;
    logic         sram_en;
    logic [3:0]   sram_we;
    logic [31:0]  sram_addr;
    logic [31:0]  sram_wdata;

    int checks = 0;
    int errors = 0;

    exe_stage #(
        .DIV_CYCLES(32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_to_EXE_valid (id_valid),
        .ID_to_EXE_bus   (id_bus),
        .EXE_allow_in    (exe_allow_in),
        .MEM_allow_in    (mem_allow_in),
        .EXE_to_MEM_valid(mem_valid),
        .EXE_to_MEM_bus  (mem_bus),
        .EXE_to_BY_bus   (by_bus),
        .data_sram_en    (sram_en),
        .data_sram_we    (sram_we),
        .data_sram_addr  (sram_addr),
        .data_sram_wdata (sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [1:0]  wd;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  exp_we;
        logic [31:0] exp_wdata;
    } mem_vec_t;

    alu_vec_t alu_vecs[16];
    alu_vec_t div_vecs[10];
    mem_vec_t mem_vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [160:0] mk_bus(input int op, input logic [31:0] s1,
                                            input logic [31:0] s2, input logic [2:0] sel,
                                            input logic rfwe, input logic [1:0] wd,
                                            input logic we, input logic en,
                                            input logic [31:0] wdata, input logic [4:0] rd,
                                            input logic [31:0] pc);
        logic [18:0] aop;
        aop = 19'd1 << op;
        return {sel, rfwe, 1'b0, wd, we, en, wdata, rd, aop, s2, s1, pc};
    endfunction

    // Issue one divide, count cycles until the result is offered to MEM, then let it leave.
    task automatic run_div(input string name, input int op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int cnt;
        id_valid = 1'b1;
        id_bus   = mk_bus(op, a, b, 3'b001, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 5'd9, 32'h100);
        @(posedge clk); #1;
        id_valid = 1'b0;
        id_bus   = '0;
        cnt = 0;
        while (!mem_valid && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk({name, "_latency"}, 32'(cnt), 32'd33);
        chk(name, mem_bus[63:32], exp);
        @(posedge clk); #1;
    endtask

    initial begin
        alu_vecs[0]  = '{ALU_OP_ADD,   32'd5,         32'd7,         32'd12};
        alu_vecs[1]  = '{ALU_OP_SUB,   32'd5,         32'd7,         32'hFFFF_FFFE};
        alu_vecs[2]  = '{ALU_OP_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1};
        alu_vecs[3]  = '{ALU_OP_SLTU,  32'hFFFF_FFFF, 32'd1,         32'd0};
        alu_vecs[4]  = '{ALU_OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        alu_vecs[5]  = '{ALU_OP_NOR,   32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_0000};
        alu_vecs[6]  = '{ALU_OP_OR,    32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
        alu_vecs[7]  = '{ALU_OP_XOR,   32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
        alu_vecs[8]  = '{ALU_OP_SLL,   32'd1,         32'h0000_003F, 32'h8000_0000};
        alu_vecs[9]  = '{ALU_OP_SRL,   32'h8000_0000, 32'd4,         32'h0800_0000};
        alu_vecs[10] = '{ALU_OP_SRA,   32'h8000_0000, 32'd4,         32'hF800_0000};
        alu_vecs[11] = '{ALU_OP_LUI,   32'h1111_1111, 32'hABCD_0000, 32'hABCD_0000};
        alu_vecs[12] = '{ALU_OP_MUL,   32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE};
        alu_vecs[13] = '{ALU_OP_MULH,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
        alu_vecs[14] = '{ALU_OP_MULHU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001};
        alu_vecs[15] = '{ALU_OP_MULH,  32'h4000_0000, 32'd4,         32'h0000_0001};

        div_vecs[0] = '{ALU_OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        div_vecs[1] = '{ALU_OP_MOD,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        div_vecs[2] = '{ALU_OP_DIVU, 32'd10,        32'd0,         32'hFFFF_FFFF};
        div_vecs[3] = '{ALU_OP_MODU, 32'd10,        32'd0,         32'd10};
        div_vecs[4] = '{ALU_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        div_vecs[5] = '{ALU_OP_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        div_vecs[6] = '{ALU_OP_DIVU, 32'd100,       32'd7,         32'd14};
        div_vecs[7] = '{ALU_OP_MODU, 32'd100,       32'd7,         32'd2};
        div_vecs[8] = '{ALU_OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
        div_vecs[9] = '{ALU_OP_MOD,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};

        mem_vecs[0] = '{32'h1000, 32'd3, RAM_WD_BYTE, 1'b1, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB};
        mem_vecs[1] = '{32'h1000, 32'd2, RAM_WD_HALF, 1'b1, 32'h0000_1234, 4'b1100, 32'h1234_1234};
        mem_vecs[2] = '{32'h1000, 32'd4, RAM_WD_WORD, 1'b1, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF};
        mem_vecs[3] = '{32'h1000, 32'd8, RAM_WD_WORD, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000};

        reset        = 1'b1;
        id_valid     = 1'b0;
        id_bus       = '0;
        mem_allow_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_allow_in", 32'(exe_allow_in), 32'd1);
        chk("rst_by_bus", 32'(by_bus == '0), 32'd1);
        chk("rst_mem_bus", 32'(mem_bus == '0), 32'd1);
        chk("rst_sram_en", 32'(sram_en), 32'd0);
        chk("rst_sram_we", 32'(sram_we), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            id_valid = 1'b1;
            id_bus   = mk_bus(alu_vecs[i].op, alu_vecs[i].a, alu_vecs[i].b, 3'b001, 1'b1,
                              2'b00, 1'b0, 1'b0, 32'h0, 5'd3, 32'h1C00_0000 + 32'(i * 4));
            @(posedge clk); #1;
            id_valid = 1'b0;
            chk($sformatf("alu%0d_result", i), mem_bus[63:32], alu_vecs[i].exp);
            chk($sformatf("alu%0d_valid", i), 32'(mem_valid), 32'd1);
            chk($sformatf("alu%0d_by", i), {29'd0, by_bus[2:0]}, 32'd7);
            chk($sformatf("alu%0d_by_res", i), by_bus[34:3], alu_vecs[i].exp);
            chk($sformatf("alu%0d_pc", i), mem_bus[31:0], 32'h1C00_0000 + 32'(i * 4));
        end
        @(posedge clk); #1;
        chk("alu_drain_valid", 32'(mem_valid), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_div($sformatf("div%0d", i), div_vecs[i].op, div_vecs[i].a, div_vecs[i].b,
                    div_vecs[i].exp);
        end

        for (int i = 0; i < 4; i++) begin
            id_valid = 1'b1;
            id_bus   = mk_bus(ALU_OP_ADD, mem_vecs[i].s1, mem_vecs[i].s2,
                              mem_vecs[i].we ? 3'b000 : 3'b010, ~mem_vecs[i].we, mem_vecs[i].wd,
                              mem_vecs[i].we, 1'b1, mem_vecs[i].wdata, 5'd4, 32'h200);
            @(posedge clk); #1;
            id_valid = 1'b0;
            chk($sformatf("mem%0d_en", i), 32'(sram_en), 32'd1);
            chk($sformatf("mem%0d_we", i), 32'(sram_we), 32'(mem_vecs[i].exp_we));
            chk($sformatf("mem%0d_addr", i), sram_addr, mem_vecs[i].s1 + mem_vecs[i].s2);
            if (mem_vecs[i].we) begin
                chk($sformatf("mem%0d_wdata", i), sram_wdata, mem_vecs[i].exp_wdata);
            end else begin
                chk($sformatf("mem%0d_ld_dv", i), {30'd0, by_bus[2:1]}, 32'd1);
            end
        end
        @(posedge clk); #1;

        // Load held by MEM back-pressure: no request until release, then exactly one.
        mem_allow_in = 1'b0;
        id_valid     = 1'b1;
        id_bus       = mk_bus(ALU_OP_ADD, 32'h2000, 32'd8, 3'b010, 1'b1, RAM_WD_WORD, 1'b0, 1'b1,
                              32'h0, 5'd6, 32'h300);
        @(posedge clk); #1;
        id_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d_allow", i), 32'(exe_allow_in), 32'd0);
            chk($sformatf("stall%0d_en", i), 32'(sram_en), 32'd0);
            chk($sformatf("stall%0d_valid", i), 32'(mem_valid), 32'd1);
            chk($sformatf("stall%0d_res", i), mem_bus[63:32], 32'h2008);
            @(posedge clk); #1;
        end
        mem_allow_in = 1'b1;
        #1;
        chk("release_en", 32'(sram_en), 32'd1);
        chk("release_we", 32'(sram_we), 32'd0);
        chk("release_allow", 32'(exe_allow_in), 32'd1);
        @(posedge clk); #1;
        chk("release_en_once", 32'(sram_en), 32'd0);
        chk("release_drain", 32'(mem_valid), 32'd0);

        // Divide finishing while MEM stalls: result must stay offered and unchanged.
        mem_allow_in = 1'b0;
        id_valid     = 1'b1;
        id_bus       = mk_bus(ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 3'b001, 1'b1, 2'b00, 1'b0, 1'b0,
                              32'h0, 5'd7, 32'h400);
        @(posedge clk); #1;
        id_valid = 1'b0;
        begin
            int cnt;
            cnt = 0;
            while (!mem_valid && cnt < 100) begin
                cnt++;
                @(posedge clk); #1;
            end
            chk("divstall_latency", 32'(cnt), 32'd33);
        end
        repeat (3) begin
            @(posedge clk); #1;
            chk("divstall_valid", 32'(mem_valid), 32'd1);
            chk("divstall_res", mem_bus[63:32], 32'hFFFF_FFFD);
            chk("divstall_allow", 32'(exe_allow_in), 32'd0);
        end
        mem_allow_in = 1'b1;
        @(posedge clk); #1;
        chk("divstall_drain", 32'(mem_valid), 32'd0);

        // Reset ten cycles into a divide, then a fresh divide must take the full latency.
        id_valid = 1'b1;
        id_bus   = mk_bus(ALU_OP_DIVU, 32'd100, 32'd7, 3'b001, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0,
                          5'd8, 32'h500);
        @(posedge clk); #1;
        id_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_exe_valid", 32'(by_bus[1]), 32'd0);
        chk("midrst_mem_valid", 32'(mem_valid), 32'd0);
        chk("midrst_allow", 32'(exe_allow_in), 32'd1);
        run_div("postrst_div", ALU_OP_DIVU, 32'd100, 32'd7, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
